// File: rtl/pipe_stage_chain.sv
// Elastic valid/ready register chain carrying a WIDTH-bit payload through STAGES stages.
// Optional 2-entry skid stages, plus global stall, flush and an occupancy count.
module pipe_stage_chain #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1,
  parameter int SKID   = 0,
  localparam int CAP   = STAGES * (1 + SKID),
  localparam int OCC_W = $clog2(CAP + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic [OCC_W-1:0] o_occupancy
);

  logic [WIDTH-1:0] main_data [STAGES];
  logic [WIDTH-1:0] skid_data [STAGES];
  logic [WIDTH-1:0] dat_in    [STAGES];
  logic [STAGES-1:0] main_valid;
  logic [STAGES-1:0] skid_valid;
  logic [STAGES:0]   rdy_chain;
  logic [STAGES-1:0] in_fire;
  logic [STAGES-1:0] out_fire;
  logic [OCC_W-1:0]  occupancy;
  logic              move;

  assign move = reset & ~i_flush & ~i_stall;

  // rdy_chain[k] is stage k's ready to its upstream; rdy_chain[STAGES] is the downstream ready.
  always_comb begin
    rdy_chain = '0;
    rdy_chain[STAGES] = i_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (SKID == 0) rdy_chain[k] = ~main_valid[k] | rdy_chain[k + 1];
      else           rdy_chain[k] = ~skid_valid[k];
    end
  end

  always_comb begin
    out_fire = main_valid & rdy_chain[STAGES:1] & {STAGES{move}};
    in_fire = '0;
    in_fire[0] = i_valid & rdy_chain[0] & move;
    dat_in[0] = i_data;
    for (int k = 1; k < STAGES; k++) begin
      in_fire[k] = out_fire[k - 1];
      dat_in[k] = main_data[k - 1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_valid <= '0;
      skid_valid <= '0;
      occupancy  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        main_data[k] <= '0;
        skid_data[k] <= '0;
      end
    end else if (i_flush) begin
      main_valid <= '0;
      skid_valid <= '0;
      occupancy  <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (SKID == 0) begin
          if (in_fire[k]) begin
            main_valid[k] <= 1'b1;
            main_data[k]  <= dat_in[k];
          end else if (out_fire[k]) begin
            main_valid[k] <= 1'b0;
          end
        // A full skid implies a full main entry, so it refills main only as main leaves.
        end else if (skid_valid[k]) begin
          if (out_fire[k]) begin
            main_data[k]  <= skid_data[k];
            skid_valid[k] <= 1'b0;
          end
        end else if (in_fire[k]) begin
          if (~main_valid[k] | out_fire[k]) begin
            main_valid[k] <= 1'b1;
            main_data[k]  <= dat_in[k];
          end else begin
            skid_valid[k] <= 1'b1;
            skid_data[k]  <= dat_in[k];
          end
        end else if (out_fire[k]) begin
          main_valid[k] <= 1'b0;
        end
      end
      if (in_fire[0] & ~out_fire[STAGES-1])      occupancy <= occupancy + OCC_W'(1);
      else if (~in_fire[0] & out_fire[STAGES-1]) occupancy <= occupancy - OCC_W'(1);
    end
  end

  assign o_ready     = rdy_chain[0] & move;
  assign o_valid     = main_valid[STAGES-1] & move;
  assign o_data      = main_data[STAGES-1];
  assign o_occupancy = occupancy;

  a_occ_cap: assert property (@(posedge clk) disable iff (!reset)
    o_occupancy <= OCC_W'(CAP));
  a_valid_occ: assert property (@(posedge clk) disable iff (!reset)
    o_valid |-> (o_occupancy != '0));
  a_full_ready: assert property (@(posedge clk) disable iff (!reset)
    ((o_occupancy == OCC_W'(CAP)) && !i_ready) |-> !o_ready);

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Drives four chain configurations from shared inputs; a per-instance FIFO model
// holds the entries each chain should contain.
module tb_pipe_stage_chain;

  logic        clk = 1'b0;
  logic        reset, i_valid, i_ready, i_stall, i_flush;
  logic [31:0] i_data;

  logic        ordy [4];
  logic        ov   [4];
  logic [31:0] od   [4];
  int          occ  [4];
  logic [1:0]  occ0, occ2;
  logic [2:0]  occ1, occ3;

  int cap_t  [4] = '{3, 4, 2, 4};
  int skid_t [4] = '{0, 1, 0, 0};

  logic [31:0] mq [4][8];
  int          mcnt [4];
  int          checks = 0;
  int          passes = 0;

  always #5 clk = ~clk;

  always_comb begin
    occ[0] = int'(occ0);
    occ[1] = int'(occ1);
    occ[2] = int'(occ2);
    occ[3] = int'(occ3);
  end

  pipe_stage_chain #(.WIDTH(32), .STAGES(3), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(ordy[0]), .i_data(i_data),
    .o_valid(ov[0]), .i_ready(i_ready), .o_data(od[0]), .i_stall(i_stall),
    .i_flush(i_flush), .o_occupancy(occ0));
  pipe_stage_chain #(.WIDTH(32), .STAGES(2), .SKID(1)) dut1 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(ordy[1]), .i_data(i_data),
    .o_valid(ov[1]), .i_ready(i_ready), .o_data(od[1]), .i_stall(i_stall),
    .i_flush(i_flush), .o_occupancy(occ1));
  pipe_stage_chain #(.WIDTH(32), .STAGES(2), .SKID(0)) dut2 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(ordy[2]), .i_data(i_data),
    .o_valid(ov[2]), .i_ready(i_ready), .o_data(od[2]), .i_stall(i_stall),
    .i_flush(i_flush), .o_occupancy(occ2));
  pipe_stage_chain #(.WIDTH(32), .STAGES(4), .SKID(0)) dut3 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(ordy[3]), .i_data(i_data),
    .o_valid(ov[3]), .i_ready(i_ready), .o_data(od[3]), .i_stall(i_stall),
    .i_flush(i_flush), .o_occupancy(occ3));

  // Called just after a falling edge; leaves time for outputs to settle before sampling.
  task automatic drive(input logic rst_n, input logic v, input logic [31:0] d,
                       input logic rdy, input logic st, input logic fl);
    reset = rst_n; i_valid = v; i_data = d; i_ready = rdy; i_stall = st; i_flush = fl;
    #2;
  endtask

  task automatic tick();
    logic fin [4];
    logic fout [4];
    logic mv;
    mv = reset && !i_flush && !i_stall;
    for (int i = 0; i < 4; i++) begin
      fin[i]  = mv && i_valid && ordy[i];
      fout[i] = mv && ov[i] && i_ready;
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (!reset || i_flush) mcnt[i] = 0;
      else begin
        if (fout[i] && mcnt[i] > 0) begin
          for (int j = 0; j < 7; j++) mq[i][j] = mq[i][j+1];
          mcnt[i]--;
        end
        if (fin[i] && mcnt[i] < 8) begin
          mq[i][mcnt[i]] = i_data;
          mcnt[i]++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 0, 32'h0, 0, 0, 0); tick();
    drive(0, 0, 32'h0, 0, 0, 0); tick();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 32'hDEADBEEF, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
        checks++; if (ov[i] !== 1'b0) $display("[TB] FAIL reset_valid dut%0d c=%0d: got %b want 0", i, c, ov[i]); else passes++;
        checks++; if (ordy[i] !== 1'b0) $display("[TB] FAIL reset_ready dut%0d c=%0d: got %b want 0", i, c, ordy[i]); else passes++;
        checks++; if (occ[i] !== 0) $display("[TB] FAIL reset_occ dut%0d c=%0d: got %0d want 0", i, c, occ[i]); else passes++;
        checks++; if (od[i] !== 32'h0) $display("[TB] FAIL reset_data dut%0d c=%0d: got %h want 0", i, c, od[i]); else passes++;
      end
      tick();
    end
    drive(1, 0, 32'h0, 1, 0, 0);
    tick();
    drive(1, 0, 32'h0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (occ[i] !== 0) $display("[TB] FAIL release_occ dut%0d: got %0d want 0", i, occ[i]); else passes++;
      checks++; if (ordy[i] !== 1'b1) $display("[TB] FAIL release_ready dut%0d: got %b want 1", i, ordy[i]); else passes++;
    end
    tick();
  endtask

  // dut0 (3 stages): datum accepted at edge t is offered before edge t+3.
  task automatic test_streaming();
    int acc, emt;
    do_reset();
    for (int c = 0; c < 15; c++) begin
      drive(1, c < 10, 32'(c + 1), 1, 0, 0);
      acc = (c < 10) ? c : 10;
      emt = (c - 3 < 0) ? 0 : ((c - 3 > 10) ? 10 : c - 3);
      checks++; if (occ[0] !== acc - emt) $display("[TB] FAIL stream_occ c=%0d: got %0d want %0d", c, occ[0], acc - emt); else passes++;
      checks++; if (ov[0] !== (c >= 3 && c < 13)) $display("[TB] FAIL stream_valid c=%0d: got %b want %b", c, ov[0], (c >= 3 && c < 13)); else passes++;
      if (c >= 3 && c < 13) begin
        checks++; if (od[0] !== 32'(c - 2)) $display("[TB] FAIL stream_data c=%0d: got %0d want %0d", c, od[0], c - 2); else passes++;
      end
      checks++; if (ordy[0] !== 1'b1) $display("[TB] FAIL stream_ready c=%0d: got %b want 1", c, ordy[0]); else passes++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    int acc;
    acc = 0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1, 1, 32'hA0 + 32'(acc), 0, 0, 0);
      if (ordy[1] === 1'b1) acc++;
      tick();
    end
    checks++; if (acc !== 4) $display("[TB] FAIL bp_accepted: got %0d want 4", acc); else passes++;
    drive(1, 0, 32'h0, 0, 0, 0);
    checks++; if (occ[1] !== 4) $display("[TB] FAIL bp_occ: got %0d want 4", occ[1]); else passes++;
    checks++; if (ordy[1] !== 1'b0) $display("[TB] FAIL bp_ready: got %b want 0", ordy[1]); else passes++;
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 32'h0, 1, 0, 0);
      checks++; if (ov[1] !== 1'b1) $display("[TB] FAIL bp_drain_valid k=%0d: got %b want 1", k, ov[1]); else passes++;
      checks++; if (od[1] !== 32'hA0 + 32'(k)) $display("[TB] FAIL bp_drain_data k=%0d: got %h want %h", k, od[1], 32'hA0 + 32'(k)); else passes++;
      tick();
    end
    drive(1, 0, 32'h0, 1, 0, 0);
    checks++; if (ov[1] !== 1'b0) $display("[TB] FAIL bp_empty_valid: got %b want 0", ov[1]); else passes++;
    checks++; if (occ[1] !== 0) $display("[TB] FAIL bp_empty_occ: got %0d want 0", occ[1]); else passes++;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 1, 32'h10, 0, 0, 0); tick();
    drive(1, 1, 32'h11, 0, 0, 0); tick();
    drive(1, 1, 32'h12, 0, 0, 0);
    checks++; if (occ[2] !== 2) $display("[TB] FAIL full_occ: got %0d want 2", occ[2]); else passes++;
    checks++; if (ordy[2] !== 1'b0) $display("[TB] FAIL full_ready: got %b want 0", ordy[2]); else passes++;
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 32'h12 + 32'(k), 1, 0, 0);
      checks++; if (ordy[2] !== 1'b1) $display("[TB] FAIL pass_ready k=%0d: got %b want 1", k, ordy[2]); else passes++;
      checks++; if (ov[2] !== 1'b1) $display("[TB] FAIL pass_valid k=%0d: got %b want 1", k, ov[2]); else passes++;
      checks++; if (od[2] !== 32'h10 + 32'(k)) $display("[TB] FAIL pass_data k=%0d: got %h want %h", k, od[2], 32'h10 + 32'(k)); else passes++;
      checks++; if (occ[2] !== 2) $display("[TB] FAIL pass_occ k=%0d: got %0d want 2", k, occ[2]); else passes++;
      tick();
    end
    drive(1, 0, 32'h0, 0, 0, 0);
    checks++; if (occ[2] !== 2) $display("[TB] FAIL pass_end_occ: got %0d want 2", occ[2]); else passes++;
    checks++; if (od[2] !== 32'h15) $display("[TB] FAIL pass_end_data: got %h want 15", od[2]); else passes++;
    tick();
  endtask

  task automatic test_flush_stall();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 32'h30 + 32'(k), 0, 0, 0); tick();
    end
    drive(1, 0, 32'h0, 0, 0, 0);
    checks++; if (occ[3] !== 3) $display("[TB] FAIL flush_pre_occ: got %0d want 3", occ[3]); else passes++;
    tick();
    drive(1, 1, 32'hBAD, 1, 1, 1);
    checks++; if (ordy[3] !== 1'b0) $display("[TB] FAIL flush_ready: got %b want 0", ordy[3]); else passes++;
    checks++; if (ov[3] !== 1'b0) $display("[TB] FAIL flush_valid: got %b want 0", ov[3]); else passes++;
    tick();
    for (int c = 0; c < 8; c++) begin
      drive(1, 0, 32'h0, 1, 0, 0);
      checks++; if (occ[3] !== 0) $display("[TB] FAIL flush_occ c=%0d: got %0d want 0", c, occ[3]); else passes++;
      checks++; if (ov[3] !== 1'b0) $display("[TB] FAIL flush_ghost c=%0d: got %b want 0", c, ov[3]); else passes++;
      tick();
    end
    drive(1, 1, 32'h77, 1, 0, 0); tick();
    for (int c = 1; c <= 4; c++) begin
      drive(1, 0, 32'h0, 1, 0, 0);
      checks++; if (ov[3] !== (c == 4)) $display("[TB] FAIL refill_valid c=%0d: got %b want %b", c, ov[3], (c == 4)); else passes++;
      if (c == 4) begin
        checks++; if (od[3] !== 32'h77) $display("[TB] FAIL refill_data: got %h want 77", od[3]); else passes++;
      end
      tick();
    end
  endtask

  task automatic test_stall_reset();
    do_reset();
    drive(1, 1, 32'h50, 0, 0, 0); tick();
    drive(1, 1, 32'h51, 0, 0, 0); tick();
    drive(1, 0, 32'h0, 0, 0, 0); tick();
    for (int c = 0; c < 4; c++) begin
      drive(1, 1, 32'h99, 1, 1, 0);
      checks++; if (ov[0] !== 1'b0) $display("[TB] FAIL stall_valid c=%0d: got %b want 0", c, ov[0]); else passes++;
      checks++; if (ordy[0] !== 1'b0) $display("[TB] FAIL stall_ready c=%0d: got %b want 0", c, ordy[0]); else passes++;
      checks++; if (od[0] !== 32'h50) $display("[TB] FAIL stall_data c=%0d: got %h want 50", c, od[0]); else passes++;
      checks++; if (occ[0] !== 2) $display("[TB] FAIL stall_occ c=%0d: got %0d want 2", c, occ[0]); else passes++;
      tick();
    end
    drive(1, 0, 32'h0, 0, 0, 0);
    checks++; if (ov[0] !== 1'b1) $display("[TB] FAIL unstall_valid: got %b want 1", ov[0]); else passes++;
    checks++; if (od[0] !== 32'h50) $display("[TB] FAIL unstall_data: got %h want 50", od[0]); else passes++;
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 32'h99, 1, 0, 0);
      checks++; if (ov[0] !== 1'b0) $display("[TB] FAIL midrst_valid c=%0d: got %b want 0", c, ov[0]); else passes++;
      checks++; if (ordy[0] !== 1'b0) $display("[TB] FAIL midrst_ready c=%0d: got %b want 0", c, ordy[0]); else passes++;
      if (c > 0) begin
        checks++; if (occ[0] !== 0) $display("[TB] FAIL midrst_occ c=%0d: got %0d want 0", c, occ[0]); else passes++;
        checks++; if (od[0] !== 32'h0) $display("[TB] FAIL midrst_data c=%0d: got %h want 0", c, od[0]); else passes++;
      end
      tick();
    end
    for (int c = 0; c < 6; c++) begin
      drive(1, 0, 32'h0, 1, 0, 0);
      checks++; if (ov[0] !== 1'b0) $display("[TB] FAIL stale_valid c=%0d: got %b want 0", c, ov[0]); else passes++;
      checks++; if (occ[0] !== 0) $display("[TB] FAIL stale_occ c=%0d: got %0d want 0", c, occ[0]); else passes++;
      tick();
    end
  endtask

  // Random traffic: chain contents must match an in-order FIFO of accepted data.
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive(1, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
      for (int i = 0; i < 4; i++) begin
        checks++; if (occ[i] !== mcnt[i]) $display("[TB] FAIL rnd_occ dut%0d c=%0d: got %0d want %0d", i, c, occ[i], mcnt[i]); else passes++;
        if (i_stall || i_flush) begin
          checks++; if (ov[i] !== 1'b0 || ordy[i] !== 1'b0) $display("[TB] FAIL rnd_frozen dut%0d c=%0d: got v=%b r=%b want 0 0", i, c, ov[i], ordy[i]); else passes++;
        end else begin
          if (ov[i] === 1'b1) begin
            checks++; if (mcnt[i] == 0 || od[i] !== mq[i][0]) $display("[TB] FAIL rnd_data dut%0d c=%0d: got %h want %h (held %0d)", i, c, od[i], mq[i][0], mcnt[i]); else passes++;
          end
          if (skid_t[i] == 0) begin
            checks++; if (ordy[i] !== (mcnt[i] < cap_t[i] || i_ready)) $display("[TB] FAIL rnd_ready dut%0d c=%0d: got %b want %b", i, c, ordy[i], (mcnt[i] < cap_t[i] || i_ready)); else passes++;
          end else if (ordy[i] === 1'b1) begin
            checks++; if (mcnt[i] >= cap_t[i]) $display("[TB] FAIL rnd_ready_full dut%0d c=%0d: got ready with %0d held, cap %0d", i, c, mcnt[i], cap_t[i]); else passes++;
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mcnt[i] = 0;
    reset = 1'b0; i_valid = 1'b1; i_data = 32'hDEADBEEF;
    i_ready = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_back_to_back();
    test_flush_stall();
    test_stall_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
